// File: rtl/dmem_if.sv
// dmem_if: load/store request bus between the datapath and the data memory responder
interface dmem_if;
    logic        req;
    logic        we;
    logic        size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        ready;
    logic        err;
    logic [31:0] rdata;
    modport master (output req, we, size, addr, wdata, input busy, ready, err, rdata);
    modport slave  (input req, we, size, addr, wdata, output busy, ready, err, rdata);
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: byte-serial big-endian data memory serviced over a req/ready handshake
module dmem_responder #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input logic   clk,
    input logic   rst,
    dmem_if.slave bus
);
    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;
    state_t        state_q, state_d;
    logic [1:0]    k_q, k_d;
    logic          we_q, we_d, size_q, size_d, err_q, err_d;
    logic [AW-1:0] addr_q, addr_d, idx;
    logic [31:0]   wdata_q, wdata_d, sh_q, sh_d, rdata_q, rdata_d;
    logic [7:0]    mem [DEPTH] = '{default: 8'h00};
    logic [7:0]    wbyte;
    logic [4:0]    sh_amt;
    logic          bad, mem_we;
    always_comb begin
        idx     = addr_q + AW'(k_q);
        // byte accesses always use lane 3, which is both wdata[7:0] and the zero-extended rdata[7:0]
        sh_amt  = {2'd3 - (size_q ? k_q : 2'd3), 3'b000};
        wbyte   = 8'(wdata_q >> sh_amt);
        bad     = (bus.size && bus.addr[1:0] != 2'b00) || (bus.addr >= 32'(DEPTH));
        mem_we  = state_q == XFER && we_q && !rst;
        state_d = state_q;
        k_d     = k_q;
        we_d    = we_q;
        size_d  = size_q;
        err_d   = err_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        sh_d    = sh_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: if (bus.req) begin
                we_d    = bus.we;
                size_d  = bus.size;
                addr_d  = bus.addr[AW-1:0];
                wdata_d = bus.wdata;
                err_d   = bad;
                k_d     = '0;
                sh_d    = '0;
                state_d = bad ? DONE : XFER;
            end
            XFER: begin
                sh_d = (sh_q & ~(32'hFF << sh_amt)) | ({24'h0, mem[idx]} << sh_amt);
                k_d  = k_q + 2'd1;
                if (k_q == (size_q ? 2'd3 : 2'd0)) begin
                    state_d = DONE;
                    rdata_d = we_q ? rdata_q : sh_d;
                end
            end
            DONE: begin
                state_d = IDLE;
                k_d     = '0;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            we_q    <= 1'b0;
            size_q  <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            sh_q    <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            we_q    <= we_d;
            size_q  <= size_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            sh_q    <= sh_d;
            rdata_q <= rdata_d;
        end
    end
    // the store array is never reset so an aborted access keeps the bytes it already wrote
    always_ff @(posedge clk) begin
        if (mem_we) mem[idx] <= wbyte;
    end
    assign bus.busy  = state_q != IDLE;
    assign bus.ready = state_q == DONE;
    assign bus.err   = state_q == DONE && err_q;
    assign bus.rdata = rdata_q;
endmodule
